// File: rtl/tag_array_assoc.sv
// Set-associative tag store: per-way {valid, tag} RAMs, 1-cycle lookup
// with per-way compare, and a flush/reset sweep that clears valid bits.
module tag_array_assoc #(
  parameter int WAYS  = 4,
  parameter int SETS  = 256,
  parameter int TAG_W = 22,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [IDX_W-1:0]      rd_index,
  input  logic [TAG_W-1:0]      rd_tag,
  output logic                  rd_done,
  output logic [WAYS*TAG_W-1:0] rd_tags_out,
  output logic [WAYS-1:0]       rd_valid_out,
  output logic [WAYS-1:0]       rd_hit_way,
  output logic                  rd_hit,
  output logic [WAY_W-1:0]      rd_hit_idx,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_index,
  input  logic [WAY_W-1:0]      wr_way,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic                  wr_valid,
  input  logic                  flush,
  output logic                  busy
);

  typedef enum logic {S_IDLE, S_SWEEP} state_e;

  state_e           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_sweep_idx, w_sweep_nxt;
  logic             r_done;
  logic [TAG_W-1:0] r_cmp_tag;
  logic             w_busy;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic [WAYS-1:0]  w_hit_way;
  logic [WAY_W-1:0] w_hit_idx;

  assign w_busy   = (r_state == S_SWEEP);
  assign w_rd_acc = rd_en & ~w_busy;
  assign w_wr_acc = wr_en & ~w_busy;

  always_comb begin
    w_state_nxt = r_state;
    w_sweep_nxt = r_sweep_idx;
    unique case (r_state)
      S_IDLE: begin
        if (flush) begin
          w_state_nxt = S_SWEEP;
          w_sweep_nxt = '0;
        end
      end
      S_SWEEP: begin
        if (flush) begin
          w_sweep_nxt = '0;
        end else if (r_sweep_idx == IDX_W'(SETS - 1)) begin
          w_state_nxt = S_IDLE;
          w_sweep_nxt = '0;
        end else begin
          w_sweep_nxt = r_sweep_idx + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_SWEEP;
        w_sweep_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_SWEEP;
      r_sweep_idx <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_idx <= w_sweep_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_done    <= 1'b0;
      r_cmp_tag <= '0;
    end else begin
      r_done <= w_rd_acc;
      if (w_rd_acc) r_cmp_tag <= rd_tag;
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic [TAG_W-1:0] r_tag_mem [SETS];
    logic             r_vld_mem [SETS];
    logic [TAG_W-1:0] r_tag_q;
    logic             r_vld_q;
    logic             w_we;

    assign w_we = w_wr_acc && (wr_way == WAY_W'(w));

    // Tags live in their own RAM so a sweep never touches them
    always_ff @(posedge clk) begin
      if (w_we) r_tag_mem[wr_index] <= wr_tag;
    end

    always_ff @(posedge clk) begin
      if (w_busy)    r_vld_mem[r_sweep_idx] <= 1'b0;
      else if (w_we) r_vld_mem[wr_index]    <= wr_valid;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_tag_q <= '0;
        r_vld_q <= 1'b0;
      end else if (w_rd_acc) begin
        r_tag_q <= r_tag_mem[rd_index];
        r_vld_q <= r_vld_mem[rd_index];
      end
    end

    assign rd_tags_out[w*TAG_W +: TAG_W] = r_tag_q;
    assign rd_valid_out[w] = r_vld_q;
    assign w_hit_way[w]    = r_vld_q && (r_tag_q == r_cmp_tag);
  end

  always_comb begin
    w_hit_idx = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_hit_way[w]) w_hit_idx = WAY_W'(w);
    end
  end

  assign rd_done    = r_done;
  assign rd_hit_way = w_hit_way;
  assign rd_hit     = |w_hit_way;
  assign rd_hit_idx = w_hit_idx;
  assign busy       = w_busy;

endmodule

// File: tb/tb_tag_array_assoc.sv
// Directed bench for tag_array_assoc: reset sweep, lookups, write
// ordering, multi-way hits, flush and reset during a sweep.
module tb_tag_array_assoc;

  localparam int WAYS  = 4;
  localparam int SETS  = 256;
  localparam int TAG_W = 22;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  rd_en;
  logic [7:0]            rd_index;
  logic [TAG_W-1:0]      rd_tag;
  logic                  rd_done;
  logic [WAYS*TAG_W-1:0] rd_tags_out;
  logic [WAYS-1:0]       rd_valid_out;
  logic [WAYS-1:0]       rd_hit_way;
  logic                  rd_hit;
  logic [1:0]            rd_hit_idx;
  logic                  wr_en;
  logic [7:0]            wr_index;
  logic [1:0]            wr_way;
  logic [TAG_W-1:0]      wr_tag;
  logic                  wr_valid;
  logic                  flush;
  logic                  busy;

  int errors = 0;
  int checks = 0;

  tag_array_assoc #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .rd_en(rd_en), .rd_index(rd_index), .rd_tag(rd_tag),
    .rd_done(rd_done), .rd_tags_out(rd_tags_out),
    .rd_valid_out(rd_valid_out), .rd_hit_way(rd_hit_way),
    .rd_hit(rd_hit), .rd_hit_idx(rd_hit_idx),
    .wr_en(wr_en), .wr_index(wr_index), .wr_way(wr_way),
    .wr_tag(wr_tag), .wr_valid(wr_valid),
    .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int idx, input int way, input int tag,
                    input bit v);
    wr_en = 1'b1; wr_index = 8'(idx); wr_way = 2'(way);
    wr_tag = TAG_W'(tag); wr_valid = v;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic lookup(input int idx, input int tag);
    rd_en = 1'b1; rd_index = 8'(idx); rd_tag = TAG_W'(tag);
    tick();
    rd_en = 1'b0;
  endtask

  // Counts busy cycles (bounded) while poking rd_en/wr_en at set 0 way 1
  task automatic count_busy(input string tag);
    int n;
    bit saw_done;
    n = 0;
    saw_done = 1'b0;
    rd_en = 1'b1; rd_index = 8'd0; rd_tag = TAG_W'('h111);
    wr_en = 1'b1; wr_index = 8'd0; wr_way = 2'd1;
    wr_tag = TAG_W'('h2AB); wr_valid = 1'b1;
    while (busy && n < 1000) begin
      n++;
      tick();
      if (rd_done) saw_done = 1'b1;
    end
    rd_en = 1'b0; wr_en = 1'b0;
    chk({tag, "_cycles"}, 128'(n), 128'd256);
    chk({tag, "_no_done"}, 128'(saw_done), 128'd0);
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; rd_index = '0; rd_tag = '0;
    wr_en = 1'b0; wr_index = '0; wr_way = '0; wr_tag = '0;
    wr_valid = 1'b0; flush = 1'b0;
    tick(); tick();
    rd_en = 1'b1; rd_index = 8'd3;
    tick();
    chk("rst_busy", 128'(busy), 128'd1);
    chk("rst_done", 128'(rd_done), 128'd0);
    chk("rst_valid", 128'(rd_valid_out), 128'd0);
    chk("rst_tags", 128'(rd_tags_out), 128'd0);
    chk("rst_hit", 128'({rd_hit, rd_hit_way, rd_hit_idx}), 128'd0);
    rst = 1'b0; rd_en = 1'b0;
    count_busy("reset_sweep");
    chk("idle_busy", 128'(busy), 128'd0);

    lookup(3, 0);
    chk("empty_done", 128'(rd_done), 128'd1);
    chk("empty_valid", 128'(rd_valid_out), 128'd0);
    chk("empty_hit", 128'(rd_hit), 128'd0);
    tick();
    chk("done_pulse", 128'(rd_done), 128'd0);

    wr(5, 2, 'h12345, 1'b1);
    lookup(5, 'h12345);
    chk("s5_done", 128'(rd_done), 128'd1);
    chk("s5_way", 128'(rd_hit_way), 128'b0100);
    chk("s5_idx", 128'(rd_hit_idx), 128'd2);
    chk("s5_tag", 128'(rd_tags_out[65:44]), 128'h12345);
    lookup(5, 'h12344);
    chk("s5_miss", 128'({rd_hit, rd_hit_way}), 128'd0);
    chk("s5_miss_vld", 128'(rd_valid_out), 128'b0100);

    wr_en = 1'b1; wr_index = 8'd7; wr_way = 2'd0;
    wr_tag = TAG_W'('h3AA); wr_valid = 1'b1;
    rd_en = 1'b1; rd_index = 8'd7; rd_tag = TAG_W'('h3AA);
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("s7_rdfirst_done", 128'(rd_done), 128'd1);
    chk("s7_rdfirst_hit", 128'(rd_hit), 128'd0);
    lookup(7, 'h3AA);
    chk("s7_hit", 128'(rd_hit), 128'd1);
    chk("s7_idx", 128'(rd_hit_idx), 128'd0);

    wr(9, 1, 'h0F0, 1'b1);
    wr(9, 3, 'h0F0, 1'b1);
    lookup(9, 'h0F0);
    chk("s9_way", 128'(rd_hit_way), 128'b1010);
    chk("s9_idx", 128'(rd_hit_idx), 128'd1);

    rd_en = 1'b1; rd_index = 8'd5; rd_tag = TAG_W'('h12345);
    tick();
    chk("b2b_1_done", 128'(rd_done), 128'd1);
    chk("b2b_1_way", 128'(rd_hit_way), 128'b0100);
    rd_index = 8'd7; rd_tag = TAG_W'('h3AA);
    tick();
    rd_en = 1'b0;
    chk("b2b_2_done", 128'(rd_done), 128'd1);
    chk("b2b_2_way", 128'(rd_hit_way), 128'b0001);

    wr(5, 2, 'h12345, 1'b0);
    lookup(5, 'h12345);
    chk("s5_inval", 128'({rd_valid_out, rd_hit}), 128'd0);

    wr(0, 0, 'h111, 1'b1);
    wr(255, 3, 'h3FFFFF, 1'b1);
    lookup(0, 'h111);
    chk("s0_pre", 128'(rd_hit_way), 128'b0001);
    lookup(255, 'h3FFFFF);
    chk("s255_pre", 128'(rd_hit_way), 128'b1000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    count_busy("flush");
    lookup(0, 'h111);
    chk("s0_post_vld", 128'(rd_valid_out), 128'd0);
    chk("s0_post_tag", 128'(rd_tags_out[21:0]), 128'h111);
    lookup(255, 'h3FFFFF);
    chk("s255_post_vld", 128'(rd_valid_out), 128'd0);
    chk("s255_post_tag", 128'(rd_tags_out[87:66]), 128'h3FFFFF);

    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (50) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    count_busy("reflush");

    wr(9, 1, 'h0F0, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (100) tick();
    rst = 1'b1; rd_en = 1'b1; rd_index = 8'd9; rd_tag = TAG_W'('h0F0);
    tick();
    chk("midrst_done", 128'(rd_done), 128'd0);
    tick();
    chk("midrst_busy", 128'(busy), 128'd1);
    chk("midrst_done2", 128'(rd_done), 128'd0);
    rst = 1'b0; rd_en = 1'b0;
    count_busy("midrst_sweep");
    lookup(9, 'h0F0);
    chk("midrst_after", 128'({rd_done, rd_hit}), 128'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
